// File: rtl/tape_out_decoder_pkg.sv
// Shared types and defaults for the tape-out decoder.
// Holds the state encoding, timing defaults and the sync marker.
package tape_out_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEADER,
    SYNC,
    DATA
  } state_t;

  localparam int DEF_PW         = 12;
  localparam int DEF_MIN_P      = 40;
  localparam int DEF_THRESH     = 400;
  localparam int DEF_MAX_P      = 2000;
  localparam int DEF_LEADER_LEN = 64;

  localparam logic [7:0] SYNC_MARK = 8'hA5;

  // Bits tried in SYNC before falling back to LEADER.
  localparam int SYNC_TRIES = 32;

endpackage

// File: rtl/tape_out_decoder_if.sv
// Byte output port of the tape-out decoder.
// Ports: out_data, out_valid, out_addr (to consumer), out_ready (from it).
interface tape_out_decoder_if;

  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_addr;

  modport master (
    output out_data,
    output out_valid,
    output out_addr,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_addr,
    output out_ready
  );

endinterface

// File: rtl/tape_out_decoder_meter.sv
// Tape period meter: sync, rising-edge detect, period count, classify.
// Ports: clock, reset, ce, tape_in in; bit_valid, bit_val, gap pulses out.
import tape_out_decoder_pkg::*;

module tape_period_meter #(
  parameter int PW     = DEF_PW,
  parameter int MIN_P  = DEF_MIN_P,
  parameter int THRESH = DEF_THRESH,
  parameter int MAX_P  = DEF_MAX_P
) (
  input  logic clock,
  input  logic reset,
  input  logic ce,
  input  logic tape_in,
  output logic bit_valid,
  output logic bit_val,
  output logic gap
);

  localparam logic [PW-1:0] MIN_C = PW'(MIN_P);
  localparam logic [PW-1:0] THR_C = PW'(THRESH);
  localparam logic [PW-1:0] MAX_C = PW'(MAX_P);
  localparam logic [PW-1:0] PRE_C = PW'(MAX_P - 1);

  logic          s0;
  logic          s1;
  logic          prev;
  logic [PW-1:0] cnt;
  logic          take;

  // Edges closer than MIN_P to the last accepted edge are glitches.
  assign take = s1 && !prev && (cnt >= MIN_C);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s0        <= 1'b0;
      s1        <= 1'b0;
      prev      <= 1'b0;
      cnt       <= '0;
      bit_valid <= 1'b0;
      bit_val   <= 1'b0;
      gap       <= 1'b0;
    end else begin
      s0        <= tape_in;
      s1        <= s0;
      bit_valid <= 1'b0;
      gap       <= 1'b0;
      if (ce) begin
        prev <= s1;
        if (take) begin
          cnt       <= PW'(1);
          bit_valid <= (cnt < MAX_C);
          bit_val   <= (cnt < THR_C);
        end else if (cnt != MAX_C) begin
          cnt <= cnt + 1'b1;
          gap <= (cnt == PRE_C);
        end
      end
    end
  end

endmodule

// File: rtl/tape_out_decoder.sv
// Tape-out decoder: leader/sync search and MSB-first byte assembly.
// Ports: clock, reset, ce, tape_in, motor; out_if byte port; block_done, overflow, busy.
import tape_out_decoder_pkg::*;

module tape_out_decoder #(
  parameter int         PW         = DEF_PW,
  parameter int         MIN_P      = DEF_MIN_P,
  parameter int         THRESH     = DEF_THRESH,
  parameter int         MAX_P      = DEF_MAX_P,
  parameter int         LEADER_LEN = DEF_LEADER_LEN,
  parameter logic [7:0] SYNC_BYTE  = SYNC_MARK
) (
  input  logic clock,
  input  logic reset,
  input  logic ce,
  input  logic tape_in,
  input  logic motor,
  tape_out_decoder_if.master out_if,
  output logic block_done,
  output logic overflow,
  output logic busy
);

  localparam logic [15:0] LL   = 16'(LEADER_LEN);
  localparam logic [5:0]  LAST = 6'(SYNC_TRIES - 1);

  logic bv;
  logic bval;
  logic gap;

  tape_period_meter #(
    .PW     (PW),
    .MIN_P  (MIN_P),
    .THRESH (THRESH),
    .MAX_P  (MAX_P)
  ) u_meter (
    .clock     (clock),
    .reset     (reset),
    .ce        (ce),
    .tape_in   (tape_in),
    .bit_valid (bv),
    .bit_val   (bval),
    .gap       (gap)
  );

  state_t      state, state_n;
  logic [15:0] lcnt, lcnt_n;
  logic [7:0]  sr, sr_n;
  logic [5:0]  scnt, scnt_n;
  logic [2:0]  bcnt, bcnt_n;
  logic [7:0]  shifted;
  logic        byte_done;
  logic        done_n;
  logic        enter_data;
  logic [7:0]  hold;
  logic        valid;
  logic [15:0] addr;
  logic        accept;

  assign shifted = {sr[6:0], bval};
  assign accept  = valid && out_if.out_ready;
  assign busy    = (state != IDLE);

  assign out_if.out_data  = hold;
  assign out_if.out_valid = valid;
  assign out_if.out_addr  = addr;

  always_comb begin
    state_n    = state;
    lcnt_n     = lcnt;
    sr_n       = sr;
    scnt_n     = scnt;
    bcnt_n     = bcnt;
    byte_done  = 1'b0;
    done_n     = 1'b0;
    enter_data = 1'b0;
    unique case (state)
      IDLE: begin
        if (bv && motor) begin
          state_n = LEADER;
          lcnt_n  = '0;
        end
      end
      LEADER: begin
        if (bv) begin
          if (!bval) begin
            if (lcnt != 16'hFFFF) lcnt_n = lcnt + 1'b1;
          end else if (lcnt >= LL) begin
            // This 1 is the first bit of the sync marker.
            state_n = SYNC;
            sr_n    = 8'h01;
            scnt_n  = 6'd1;
          end else begin
            lcnt_n = '0;
          end
        end
      end
      SYNC: begin
        if (gap) begin
          state_n = IDLE;
        end else if (bv) begin
          sr_n   = shifted;
          scnt_n = scnt + 1'b1;
          if (shifted == SYNC_BYTE) begin
            state_n    = DATA;
            bcnt_n     = '0;
            enter_data = 1'b1;
          end else if (scnt == LAST) begin
            state_n = LEADER;
            lcnt_n  = '0;
          end
        end
      end
      DATA: begin
        if (gap) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (bv) begin
          sr_n      = shifted;
          bcnt_n    = bcnt + 1'b1;
          byte_done = (bcnt == 3'd7);
        end
      end
      default: state_n = IDLE;
    endcase
    if (!motor) begin
      state_n    = IDLE;
      done_n     = 1'b0;
      byte_done  = 1'b0;
      enter_data = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lcnt       <= '0;
      sr         <= '0;
      scnt       <= '0;
      bcnt       <= '0;
      block_done <= 1'b0;
      overflow   <= 1'b0;
      hold       <= '0;
      valid      <= 1'b0;
      addr       <= '0;
    end else begin
      state      <= state_n;
      lcnt       <= lcnt_n;
      sr         <= sr_n;
      scnt       <= scnt_n;
      bcnt       <= bcnt_n;
      block_done <= done_n;
      if (enter_data) overflow <= 1'b0;
      // A byte may load in the same clock the old one leaves.
      if (byte_done) begin
        if (!valid || accept) begin
          hold  <= shifted;
          valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (accept) begin
        valid <= 1'b0;
      end
      if (enter_data)  addr <= '0;
      else if (accept) addr <= addr + 1'b1;
    end
  end

endmodule

// File: tb/tb_tape_out_decoder.sv
// Self-checking bench for tape_out_decoder.
// Random timing/data against a bit-list reference decoder.
module tb_tape_out_decoder;
  import tape_out_decoder_pkg::*;

  localparam int LLEN = 16;
  localparam int MAXP = 80;

  logic clock = 0;
  logic reset = 0;
  logic ce = 0;
  logic tape_in = 0;
  logic motor = 0;
  logic block_done, overflow, busy;

  tape_out_decoder_if bus();

  tape_out_decoder #(
    .PW(8), .MIN_P(4), .THRESH(20), .MAX_P(MAXP),
    .LEADER_LEN(LLEN), .SYNC_BYTE(8'hA5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ce         (ce),
    .tape_in    (tape_in),
    .motor      (motor),
    .out_if     (bus),
    .block_done (block_done),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  logic [7:0]  got_d[$];
  logic [15:0] got_a[$];
  bit          bits[$];

  always @(negedge clock) begin
    if (reset) begin
      if (bus.out_valid && bus.out_ready) begin
        got_d.push_back(bus.out_data);
        got_a.push_back(bus.out_addr);
      end
      if (block_done) n_done++;
    end
  end

  // One ce tick at a given tape level; ce is randomly gapped.
  task automatic tick(input logic lvl);
    logic c;
    int   tries;
    tries = 0;
    tape_in = lvl;
    do begin
      c = ($urandom_range(0, 3) != 0) || (tries >= 8);
      ce = c;
      tries++;
      @(posedge clock);
      #1;
    end while (!c);
  endtask

  task automatic silence(input int n);
    repeat (n) tick(0);
  endtask

  task automatic period(input bit b, input bit g);
    int p, h;
    p = b ? int'($urandom_range(8, 14)) : int'($urandom_range(26, 40));
    h = p / 2;
    bits.push_back(b);
    if (g) begin
      tick(1);
      tick(0);
      h -= 2;
    end
    repeat (h) tick(1);
    repeat (p - p / 2) tick(0);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit g);
    for (int i = 7; i >= 0; i--) period(v[i], g);
  endtask

  task automatic leader(input int n);
    repeat (n) period(0, 0);
  endtask

  // Closing edge decodes the last bit; the silence then forms the gap.
  task automatic edge_end();
    repeat (5) tick(1);
    silence(MAXP + 20);
  endtask

  task automatic frame(input logic [7:0] d[$], input bit g);
    bits.delete();
    silence(MAXP + 20);
    leader(LLEN + 4);
    send_byte(8'hA5, 0);
    foreach (d[i]) send_byte(d[i], g);
    edge_end();
  endtask

  // Reference: bits[0] wakes the decoder; find a 1 after >= LLEN zeros,
  // find A5 within 32 bits from it, then cut whole bytes MSB-first.
  function automatic void model(input bit b[$], output logic [7:0] q[$]);
    int run, j, d;
    logic [7:0] w;
    q = {};
    run = 0;
    j = -1;
    d = -1;
    for (int i = 1; i < b.size() && j < 0; i++) begin
      if (!b[i]) run++;
      else if (run >= LLEN) j = i;
      else run = 0;
    end
    if (j < 0) return;
    for (int k = j; k < b.size() && k < j + 32 && d < 0; k++) begin
      w = 8'h00;
      for (int m = 0; m < 8; m++) if (k - m >= j) w[m] = b[k - m];
      if (w == 8'hA5) d = k + 1;
    end
    if (d < 0) return;
    for (int k = d; k + 8 <= b.size(); k += 8) begin
      w = 8'h00;
      for (int m = 0; m < 8; m++) w = {w[6:0], b[k + m]};
      q.push_back(w);
    end
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", bus.out_valid); end
    n_chk++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL rst_data got %h want 00", bus.out_data); end
    n_chk++; if (bus.out_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_addr got %h want 0000", bus.out_addr); end
    n_chk++; if (block_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", block_done); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b want 0", overflow); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    @(posedge clock);
    #1;
    reset = 1;
    motor = 1;
    bus.out_ready = 1;
  endtask

  task automatic test_block();
    logic [7:0] d[$];
    logic [7:0] e[$];
    int done0;
    d = {8'h3C, 8'hFF, 8'($urandom), 8'($urandom)};
    got_d.delete();
    got_a.delete();
    done0 = n_done;
    frame(d, 0);
    model(bits, e);
    n_chk++; if (got_d.size() !== e.size()) begin n_fail++; $display("FAIL blk_count got %0d want %0d", got_d.size(), e.size()); end
    for (int i = 0; i < e.size(); i++) begin
      n_chk++; if (got_d[i] !== e[i]) begin n_fail++; $display("FAIL blk_data[%0d] got %h want %h", i, got_d[i], e[i]); end
      n_chk++; if (got_a[i] !== 16'(i)) begin n_fail++; $display("FAIL blk_addr[%0d] got %h want %h", i, got_a[i], i); end
    end
    n_chk++; if (n_done - done0 !== 1) begin n_fail++; $display("FAIL blk_done got %0d want 1", n_done - done0); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL blk_busy got %b want 0", busy); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL blk_ovf got %b want 0", overflow); end
  endtask

  task automatic test_short_leader();
    logic [7:0] e[$];
    logic [7:0] d0, d1;
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    got_d.delete();
    got_a.delete();
    bits.delete();
    silence(MAXP + 20);
    leader(11);
    period(1, 0);
    leader(LLEN + 4);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL short_busy got %b want 1", busy); end
    n_chk++; if (got_d.size() !== 0) begin n_fail++; $display("FAIL short_out got %0d want 0", got_d.size()); end
    send_byte(8'hA5, 0);
    send_byte(d0, 0);
    send_byte(d1, 0);
    edge_end();
    model(bits, e);
    n_chk++; if (got_d.size() !== e.size()) begin n_fail++; $display("FAIL short_count got %0d want %0d", got_d.size(), e.size()); end
    for (int i = 0; i < e.size(); i++) begin
      n_chk++; if (got_d[i] !== e[i]) begin n_fail++; $display("FAIL short_data[%0d] got %h want %h", i, got_d[i], e[i]); end
    end
  endtask

  task automatic test_glitch();
    logic [7:0] d[$];
    logic [7:0] e[$];
    d = {8'($urandom), 8'($urandom), 8'($urandom)};
    got_d.delete();
    got_a.delete();
    frame(d, 1);
    model(bits, e);
    n_chk++; if (got_d.size() !== e.size()) begin n_fail++; $display("FAIL glitch_count got %0d want %0d", got_d.size(), e.size()); end
    for (int i = 0; i < e.size(); i++) begin
      n_chk++; if (got_d[i] !== e[i]) begin n_fail++; $display("FAIL glitch_data[%0d] got %h want %h", i, got_d[i], e[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d[$];
    logic [7:0] e[$];
    d = {8'($urandom), 8'($urandom), 8'($urandom)};
    bus.out_ready = 0;
    got_d.delete();
    got_a.delete();
    frame(d, 0);
    model(bits, e);
    n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b want 1", bus.out_valid); end
    n_chk++; if (bus.out_data !== e[0]) begin n_fail++; $display("FAIL bp_data got %h want %h", bus.out_data, e[0]); end
    n_chk++; if (bus.out_addr !== 16'h0000) begin n_fail++; $display("FAIL bp_addr got %h want 0000", bus.out_addr); end
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_ovf got %b want 1", overflow); end
    bus.out_ready = 1;
    tick(0);
    tick(0);
    n_chk++; if (got_d.size() !== 1) begin n_fail++; $display("FAIL bp_accepts got %0d want 1", got_d.size()); end
    n_chk++; if (bus.out_addr !== 16'h0001) begin n_fail++; $display("FAIL bp_addr_after got %h want 0001", bus.out_addr); end
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_after got %b want 0", bus.out_valid); end
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_motor_drop();
    logic [7:0] v;
    int done0;
    v = 8'($urandom);
    got_d.delete();
    got_a.delete();
    bits.delete();
    done0 = n_done;
    silence(MAXP + 20);
    leader(LLEN + 4);
    send_byte(8'hA5, 0);
    for (int i = 7; i >= 4; i--) period(v[i], 0);
    repeat (6) tick(1);
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL motor_ovf_clr got %b want 0", overflow); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL motor_busy_pre got %b want 1", busy); end
    motor = 0;
    @(posedge clock);
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL motor_busy got %b want 0", busy); end
    for (int i = 3; i >= 0; i--) period(v[i], 0);
    send_byte(8'($urandom), 0);
    edge_end();
    n_chk++; if (got_d.size() !== 0) begin n_fail++; $display("FAIL motor_bytes got %0d want 0", got_d.size()); end
    n_chk++; if (n_done - done0 !== 0) begin n_fail++; $display("FAIL motor_done got %0d want 0", n_done - done0); end
    motor = 1;
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 0;
    bits.delete();
    silence(MAXP + 20);
    leader(LLEN + 4);
    send_byte(8'hA5, 0);
    send_byte(8'($urandom), 0);
    repeat (10) tick(1);
    n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid_pre got %b want 1", bus.out_valid); end
    reset = 0;
    #1;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", bus.out_valid); end
    n_chk++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL mid_data got %h want 00", bus.out_data); end
    n_chk++; if (bus.out_addr !== 16'h0000) begin n_fail++; $display("FAIL mid_addr got %h want 0000", bus.out_addr); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_ovf got %b want 0", overflow); end
    n_chk++; if (block_done !== 1'b0) begin n_fail++; $display("FAIL mid_done got %b want 0", block_done); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", busy); end
    @(posedge clock);
    #1;
    reset = 1;
    bus.out_ready = 1;
  endtask

  initial begin
    bus.out_ready = 0;
    test_reset();
    test_block();
    test_short_leader();
    test_glitch();
    test_backpressure();
    test_motor_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
